// File: rtl/pipeline_skid_stage.sv
// pipeline_skid_stage
//   Inter-stage pipeline register with a valid/ready handshake and a
//   2-entry skid buffer. in_ready and out_valid come straight from flops, so
//   a stall never creates a combinational ready path through the stage.
//   A synchronous flush kills every held entry and presents NOP_VALUE.
//
// Ports
//   clk        in   1       clock, rising edge
//   reset      in   1       asynchronous, active-high reset
//   flush      in   1       synchronous kill of all held entries
//   in_valid   in   1       upstream presents a payload
//   in_ready   out  1       stage can accept (registered)
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       out_data holds a live payload (registered)
//   out_ready  in   1       downstream accepts out_data this cycle
//   out_data   out  DATA_W  payload to next stage (registered)
//   occupancy  out  2       held entries, 0..2
//   stall_cnt  out  CNT_W   saturating count of out_valid & ~out_ready cycles
//   flush_cnt  out  CNT_W   saturating count of flushes that discarded work
module pipeline_skid_stage #(
   parameter int               DATA_W    = 64,
   parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
   parameter int               CNT_W     = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   // State encoding doubles as the occupancy count.
   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] TWO   = 2'd2;

   logic [1:0]        stateReg, stateNext;
   logic [DATA_W-1:0] mainReg, mainNext;
   logic [DATA_W-1:0] skidReg, skidNext;
   logic              inReadyReg;
   logic              outValidReg;
   logic              inFire;
   logic              outFire;

   assign inFire  = in_valid & inReadyReg;
   assign outFire = outValidReg & out_ready;

   always_comb begin
      stateNext = stateReg;
      mainNext  = mainReg;
      skidNext  = skidReg;
      if (flush) begin
         // Flush wins over everything; a same-cycle in_fire is simply dropped.
         stateNext = EMPTY;
         mainNext  = NOP_VALUE;
         skidNext  = NOP_VALUE;
      end else begin
         case (stateReg)
            EMPTY: begin
               if (inFire) begin
                  stateNext = ONE;
                  mainNext  = in_data;
               end
            end
            ONE: begin
               if (inFire && outFire) begin
                  mainNext = in_data;
               end else if (inFire) begin
                  stateNext = TWO;
                  skidNext  = in_data;
               end else if (outFire) begin
                  stateNext = EMPTY;
                  mainNext  = NOP_VALUE;
               end
            end
            TWO: begin
               // in_ready is low here, so only the drain case moves anything.
               if (outFire) begin
                  stateNext = ONE;
                  mainNext  = skidReg;
                  skidNext  = NOP_VALUE;
               end
            end
            default: begin
               stateNext = EMPTY;
               mainNext  = NOP_VALUE;
               skidNext  = NOP_VALUE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stateReg    <= EMPTY;
         mainReg     <= NOP_VALUE;
         skidReg     <= NOP_VALUE;
         inReadyReg  <= 1'b1;
         outValidReg <= 1'b0;
      end else begin
         stateReg    <= stateNext;
         mainReg     <= mainNext;
         skidReg     <= skidNext;
         // Handshake flags are decoded from the next state so they are
         // flop outputs and never see in_valid/out_ready combinationally.
         inReadyReg  <= (stateNext != TWO);
         outValidReg <= (stateNext != EMPTY);
      end
   end

   // Saturating event counters: index 0 = stall, index 1 = flush.
   logic [1:0]       cntInc;
   logic [CNT_W-1:0] cntReg [2];

   assign cntInc[0] = outValidReg & ~out_ready & ~flush;
   assign cntInc[1] = flush & ((stateReg != EMPTY) | inFire);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : gCnt
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               cntReg[gi] <= '0;
            end else if (cntInc[gi] && (cntReg[gi] != {CNT_W{1'b1}})) begin
               cntReg[gi] <= cntReg[gi] + 1'b1;
            end
         end
      end
   endgenerate

   assign in_ready  = inReadyReg;
   assign out_valid = outValidReg;
   assign out_data  = mainReg;
   assign occupancy = stateReg;
   assign stall_cnt = cntReg[0];
   assign flush_cnt = cntReg[1];

endmodule
